// File: rtl/mem_pkg.sv
// Shared constants and types for the pipelined memory responder.
// The burst FSM state type is only referenced when MEM_BURST_EN is defined.
package mem_pkg;
  localparam int WORD_W          = 16;
  localparam int BLOCK_WORDS     = 8;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic {IDLE, BURST} burst_state_e;
endpackage

// File: rtl/pipelined_mem_responder_if.sv
// Request/response bus between the cache fill logic (master) and the memory responder (slave).
// MEM_BURST_EN adds the burst request qualifier.
interface pipelined_mem_responder_if;
  import mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [15:0]       addr;
  logic [WORD_W-1:0] data_in;
  logic              ready;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic [3:0]        outstanding;
`ifdef MEM_BURST_EN
  logic              burst;

  modport master (output enable, wr, addr, data_in, burst,
                  input  ready, data_out, data_valid, outstanding);
  modport slave  (input  enable, wr, addr, data_in, burst,
                  output ready, data_out, data_valid, outstanding);
`else
  modport master (output enable, wr, addr, data_in,
                  input  ready, data_out, data_valid, outstanding);
  modport slave  (input  enable, wr, addr, data_in,
                  output ready, data_out, data_valid, outstanding);
`endif
endinterface

// File: rtl/pipelined_mem_responder_latency_pipe.sv
// Valid+data shift register of depth DEPTH with synchronous active-low clear.
// Data is forced to zero in stages whose valid bit is clear.
module latency_pipe #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_dat [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_vld ? i_dat : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];
endmodule

// File: rtl/pipelined_mem_responder.sv
// Main-memory model below the cache controller: single-word reads return after LATENCY cycles, fully pipelined.
// MEM_BURST_EN adds 8-word block fills; ready drops while the block is being issued.
module pipelined_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  pipelined_mem_responder_if.slave    bus
);
  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [3:0]        r_outstanding;

  logic              w_issue;
  logic              w_ready;
  logic [15:0]       w_rd_addr;
  logic [15:0]       w_unused_addr;
  logic [ADDR_W-1:0] w_wr_word;
  logic [ADDR_W-1:0] w_rd_word;
  logic              w_wr_acc;
  logic [WORD_W-1:0] w_rd_dat;
  logic              w_pipe_vld;
  logic [WORD_W-1:0] w_pipe_dat;

`ifdef MEM_BURST_EN
  burst_state_e r_state, w_state_nxt;
  logic [2:0]   r_cnt, w_cnt_nxt;
  logic [11:0]  r_base, w_base_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // The accepting edge issues word 0; BURST issues words 1..7 one per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_base_nxt  = r_base;
    w_ready     = 1'b1;
    w_issue     = bus.enable && !bus.wr;
    w_rd_addr   = bus.addr;
    case (r_state)
      IDLE: begin
        if (bus.enable && !bus.wr && bus.burst) begin
          w_state_nxt = BURST;
          w_cnt_nxt   = 3'd1;
          w_base_nxt  = bus.addr[15:4];
          w_rd_addr   = {bus.addr[15:4], 4'b0000};
        end
      end
      BURST: begin
        w_ready   = 1'b0;
        w_issue   = 1'b1;
        w_rd_addr = {r_base, r_cnt, 1'b0};
        w_cnt_nxt = r_cnt + 3'd1;
        if (r_cnt == 3'(BLOCK_WORDS - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  assign w_ready   = 1'b1;
  assign w_issue   = bus.enable && !bus.wr;
  assign w_rd_addr = bus.addr;
`endif

  // addr[0] and bits above ADDR_W are deliberately ignored (aliasing).
  assign w_unused_addr = w_rd_addr;
  assign w_rd_word     = w_rd_addr[ADDR_W:1];
  assign w_wr_word     = bus.addr[ADDR_W:1];
  assign w_wr_acc      = bus.enable && bus.wr && w_ready;
  assign w_rd_dat      = r_mem[w_rd_word];

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_word] <= bus.data_in;
  end

  latency_pipe #(
    .DEPTH (LATENCY),
    .W     (WORD_W)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_issue),
    .i_dat (w_rd_dat),
    .o_vld (w_pipe_vld),
    .o_dat (w_pipe_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else if (w_issue && !w_pipe_vld) begin
      r_outstanding <= r_outstanding + 4'd1;
    end else if (!w_issue && w_pipe_vld) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  assign bus.ready       = w_ready;
  assign bus.data_out    = w_pipe_dat;
  assign bus.data_valid  = w_pipe_vld;
  assign bus.outstanding = r_outstanding;
endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Bench for pipelined_mem_responder: directed cases plus random traffic against a queue-based response model.
// Burst case is exercised only when MEM_BURST_EN is defined.
module tb_pipelined_mem_responder;
  localparam int ADDR_W  = 10;
  localparam int LATENCY = 4;

  typedef struct {
    logic [15:0] dat;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  logic cur_burst = 1'b0;

  pipelined_mem_responder_if bus();
`ifdef MEM_BURST_EN
  assign bus.burst = cur_burst;
`endif

  pipelined_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mm [2**ADDR_W];
  resp_t       q[$];
  int          edge_n    = 0;
  int          burst_rem = 0;
  int          n_cmp     = 0;
  int          n_fail    = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock: drive request, advance model at the edge, compare at the following negedge.
  task automatic cyc(input logic r, input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic        acc;
    logic [15:0] ba;
    logic        exp_v;
    rst            = r;
    bus.enable     = en;
    bus.wr         = w;
    bus.addr       = a;
    bus.data_in    = d;
    acc            = en && (burst_rem == 0);
    @(posedge clk);
    edge_n++;
    if (!r) begin
      q.delete();
      burst_rem = 0;
    end else if (burst_rem > 0) begin
      burst_rem--;
    end else if (acc && w) begin
      mm[a[ADDR_W:1]] = d;
    end else if (acc && cur_burst) begin
      for (int k = 0; k < 8; k++) begin
        ba = {a[15:4], k[2:0], 1'b0};
        q.push_back('{dat: mm[ba[ADDR_W:1]], due: edge_n + k + LATENCY - 1});
      end
      burst_rem = 7;
    end else if (acc) begin
      q.push_back('{dat: mm[a[ADDR_W:1]], due: edge_n + LATENCY - 1});
    end
    @(negedge clk);
    exp_v = (q.size() > 0) && (q[0].due == edge_n);
    check("data_valid", {15'd0, bus.data_valid}, {15'd0, exp_v});
    check("data_out", bus.data_out, exp_v ? q[0].dat : 16'h0000);
    check("outstanding", {12'd0, bus.outstanding}, 16'(q.size()));
    check("ready", {15'd0, bus.ready}, {15'd0, (burst_rem == 0)});
    if (exp_v) void'(q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [15:0] a;
    rst = 1'b0; bus.enable = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;

    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Single write then read: 4-cycle latency.
    cyc(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(5);

    // Preload and back-to-back reads.
    cyc(1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111);
    cyc(1'b1, 1'b1, 1'b1, 16'h0002, 16'h2222);
    cyc(1'b1, 1'b1, 1'b1, 16'h0004, 16'h3333);
    cyc(1'b1, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000);
    idle(5);

    // Read-then-write hazard on the same word.
    cyc(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555);
    cyc(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(5);

    // Address aliasing: byte bit and bits above ADDR_W are ignored.
    cyc(1'b1, 1'b1, 1'b1, 16'h0021, 16'h1234);
    cyc(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h8020, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0821, 16'h0000);
    idle(5);

    // Reset with two reads in flight drops them.
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(6);

    // Random traffic over a 16-word window with aliased upper/byte bits.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, 16'((16'h80 + i) << 1), 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      a = 16'((16'h80 + $urandom_range(0, 15)) << 1);
      a[0] = 1'($urandom);
      a[15:11] = 5'($urandom);
      cyc(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), a, 16'($urandom));
    end
    idle(6);

`ifdef MEM_BURST_EN
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 16'(16'h0030 + 2 * i), 16'(16'hC000 + i));
    cur_burst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 16'h0036, 16'h0000);
    cur_burst = 1'b0;
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'($urandom), 16'h0030, 16'hDEAD);
    idle(6);
    cyc(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    idle(5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
